led_fade_pwm: RTL and testbench
===============================

LED_FADE_PWM -- requirements
Module: led_fade_pwm

Interface
REQ-001 SHALL have parameter N, default 6, number of LED channels.
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter and brightness width.
REQ-003 SHALL have parameter FADE_DIV, default 1000, clk cycles per fade tick (legal range 1..2^24-1).
REQ-004 SHALL have parameter FADE_STEP, default 8, level decrement per fade tick (PWM_BITS wide).
REQ-005 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port: reset  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port: led_in  input  N  one-hot/any LED pattern from upstream shifter; 1 = channel lit.
REQ-008 SHALL have port: bright_max  input  PWM_BITS  brightness loaded into a lit channel.
REQ-009 SHALL have port: en  input  1  output enable; 0 forces led_out low, counters keep running.
REQ-010 SHALL have port: led_out  output  N  registered PWM drive to physical LEDs.
REQ-011 SHALL have port: pwm_wrap  output  1  registered one-cycle pulse at each PWM period start.

Function
REQ-012 SHALL run free PWM counter cnt (PWM_BITS), +1 per cycle, wrapping 2^PWM_BITS-1 -> 0.
REQ-013 SHALL run prescaler 0..FADE_DIV-1; fade_tick high the cycle prescaler == FADE_DIV-1, then prescaler -> 0; FADE_DIV=1 gives tick every cycle.
REQ-014 SHALL, per channel i, set level_i <= bright_max next cycle when led_in[i]=1, every cycle (tracks bright_max changes).
REQ-015 SHALL, when led_in[i]=0 and fade_tick=1, set level_i <= level_i - FADE_STEP if level_i > FADE_STEP, else 0 (saturate, no wrap).
REQ-016 SHALL hold level_i otherwise; led_in[i]=1 wins over simultaneous fade_tick.
REQ-017 SHALL latch duty_i <= level_i only in the cycle cnt == 2^PWM_BITS-1 (glitch-free period boundary).
REQ-018 SHALL register led_out[i] <= en & (cnt < duty_i); one-cycle latency from compare to pin.
REQ-019 SHALL give duty 0 -> always low; duty 2^PWM_BITS-1 -> high 2^PWM_BITS-1 of 2^PWM_BITS cycles.
REQ-020 SHALL register pwm_wrap <= (cnt == 2^PWM_BITS-1); exactly one cycle high per period.
REQ-021 SHALL not clamp level_i to a lowered bright_max while led_in[i]=0; decay continues from current level.
REQ-022 SHALL make en changes take effect on led_out the next cycle, independent of period boundary.

Reset
REQ-023 SHALL on reset clear cnt, prescaler, all level_i, all duty_i, led_out and pwm_wrap to 0.
REQ-024 SHALL let reset asserted mid-period or mid-fade abort immediately; first post-reset cycle counts from cnt=0.

Structure
REQ-025 SHALL take default parameter values (N, PWM_BITS, FADE_DIV, FADE_STEP) from shared package led_pkg.
REQ-026 SHALL instantiate N copies of sub-module led_pwm_chan (level, duty, compare, output flop); cnt and prescaler stay in top.
REQ-027 SHALL share one cnt and one fade_tick across all channels.

Verification (bench params N=4, PWM_BITS=4, FADE_DIV=4, FADE_STEP=4)
REQ-028 SHALL cover reset: after reset, led_out=0, pwm_wrap=0; first pwm_wrap 16 cycles after reset release.
REQ-029 SHALL cover full on: led_in=4'b0001, bright_max=15, en=1 -> from next period led_out[0] high 15 of 16 cycles, others 0.
REQ-030 SHALL cover fade: led_in 0001->0010 with bright_max=12 -> level_0 steps 12,8,4,0 every 4 cycles; led_out[0] duty per period follows latched level.
REQ-031 SHALL cover boundaries: bright_max=0 -> led_out constantly 0; FADE_STEP > level -> level 0 not wrap; load beats simultaneous tick.
REQ-032 SHALL cover en: en=0 mid-period -> led_out=0 next cycle, cnt and pwm_wrap cadence unchanged; en=1 resumes same cycle-accurate duty.
REQ-033 SHALL cover mid-operation reset: reset during fade at level 8 -> all levels 0, led_out 0, no residual glow after release.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared default parameters for the LED fade PWM block
package led_pkg;

    localparam int LED_N         = 6;
    localparam int LED_PWM_BITS  = 8;
    localparam int LED_FADE_DIV  = 1000;
    localparam int LED_FADE_STEP = 8;

    localparam int LED_PRESC_BITS = 24;

endpackage

// File: rtl/led_pwm_chan.sv
// rtl/led_pwm_chan.sv - one LED channel: brightness level, period-latched duty, PWM compare flop
module led_pwm_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS  = LED_PWM_BITS,
    parameter int FADE_STEP = LED_FADE_STEP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lit_i,
    input  logic [PWM_BITS-1:0] bright_max_i,
    input  logic                fade_tick_i,
    input  logic [PWM_BITS-1:0] cnt_i,
    input  logic                cnt_last_i,
    input  logic                en_i,
    output logic                led_o
);

    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

    always_comb begin
        level_d = level_q;
        if (lit_i) begin
            level_d = bright_max_i;
        end else if (fade_tick_i) begin
            // Saturate at zero so a large step never wraps to full brightness.
            level_d = (level_q > STEP) ? (level_q - STEP) : '0;
        end
        duty_d = cnt_last_i ? level_q : duty_q;
        led_d  = en_i & (cnt_i < duty_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            duty_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            duty_q  <= duty_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - N-channel LED PWM driver with timed brightness fade-out
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int N         = LED_N,
    parameter int PWM_BITS  = LED_PWM_BITS,
    parameter int FADE_DIV  = LED_FADE_DIV,
    parameter int FADE_STEP = LED_FADE_STEP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        led_in,
    input  logic [PWM_BITS-1:0] bright_max,
    input  logic                en,
    output logic [N-1:0]        led_out,
    output logic                pwm_wrap
);

    localparam logic [LED_PRESC_BITS-1:0] PRESC_LAST = LED_PRESC_BITS'(FADE_DIV - 1);

    logic [PWM_BITS-1:0]       cnt_q, cnt_d;
    logic [LED_PRESC_BITS-1:0] presc_q, presc_d;
    logic                      wrap_q, wrap_d;
    logic                      fade_tick;
    logic                      cnt_last;

    always_comb begin
        cnt_last  = (cnt_q == {PWM_BITS{1'b1}});
        fade_tick = (presc_q == PRESC_LAST);
        cnt_d     = cnt_q + 1'b1;
        presc_d   = fade_tick ? '0 : (presc_q + 1'b1);
        wrap_d    = cnt_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            presc_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign pwm_wrap = wrap_q;

    // All channels share one counter and one fade tick so they stay phase-aligned.
    for (genvar i = 0; i < N; i++) begin : g_chan
        led_pwm_chan #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .lit_i        (led_in[i]),
            .bright_max_i (bright_max),
            .fade_tick_i  (fade_tick),
            .cnt_i        (cnt_q),
            .cnt_last_i   (cnt_last),
            .en_i         (en),
            .led_o        (led_out[i])
        );
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb/tb_led_fade_pwm.sv - directed self-checking bench for led_fade_pwm
module tb_led_fade_pwm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] led_in = 4'b0000;
    logic [3:0] bright_max = 4'd0;
    logic       en = 1'b0;
    logic [3:0] led_out;
    logic       pwm_wrap;

    int checks = 0;
    int failures = 0;
    int hi[4];

    logic [3:0] lvl0, lvl1, lvl2, lvl3;

    led_fade_pwm #(
        .N         (4),
        .PWM_BITS  (4),
        .FADE_DIV  (4),
        .FADE_STEP (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_in),
        .bright_max (bright_max),
        .en         (en),
        .led_out    (led_out),
        .pwm_wrap   (pwm_wrap)
    );

    assign lvl0 = dut.g_chan[0].u_chan.level_q;
    assign lvl1 = dut.g_chan[1].u_chan.level_q;
    assign lvl2 = dut.g_chan[2].u_chan.level_q;
    assign lvl3 = dut.g_chan[3].u_chan.level_q;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_wrap();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!pwm_wrap && n < 40);
        checks++;
        if (pwm_wrap !== 1'b1) begin
            failures++;
            $display("FAIL sync_wrap: got no pwm_wrap within %0d cycles expected one", n);
        end
    endtask

    // Call in a wrap cycle; counts high cycles per channel over the next period.
    task automatic measure_period();
        int wraps;
        wraps = 0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            for (int c = 0; c < 4; c++) hi[c] += int'(led_out[c]);
            if (pwm_wrap) wraps++;
        end
        checks++;
        if (wraps != 1 || pwm_wrap !== 1'b1) begin
            failures++;
            $display("FAIL wrap_cadence: got %0d wraps (last=%b) expected 1 at period end", wraps, pwm_wrap);
        end
    endtask

    task automatic test_reset();
        int first;
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (led_out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_led_out: got %b expected 0000", led_out);
        end
        checks++;
        if (pwm_wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_pwm_wrap: got %b expected 0", pwm_wrap);
        end
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 40 && first == 0; i++) begin
            step();
            if (pwm_wrap) first = i;
        end
        checks++;
        if (first != 16) begin
            failures++;
            $display("FAIL first_wrap: got %0d cycles expected 16", first);
        end
    endtask

    task automatic test_full_on();
        led_in = 4'b0001;
        bright_max = 4'd15;
        en = 1'b1;
        sync_wrap();
        measure_period();
        checks++;
        if (hi[0] != 15) begin
            failures++;
            $display("FAIL full_on_ch0: got %0d high cycles expected 15", hi[0]);
        end
        checks++;
        if (hi[1] + hi[2] + hi[3] != 0) begin
            failures++;
            $display("FAIL full_on_others: got %0d high cycles expected 0", hi[1] + hi[2] + hi[3]);
        end
    endtask

    task automatic test_back_to_back();
        measure_period();
        checks++;
        if (hi[0] != 15) begin
            failures++;
            $display("FAIL back_to_back_ch0: got %0d high cycles expected 15", hi[0]);
        end
    endtask

    task automatic test_fade();
        int on0, on1;
        logic [3:0] exp;
        led_in = 4'b0001;
        bright_max = 4'd12;
        sync_wrap();
        led_in = 4'b0010;
        on0 = 0;
        on1 = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            on0 += int'(led_out[0]);
            on1 += int'(led_out[1]);
            // Lowering bright_max must not clamp the fading channel.
            if (k == 2) bright_max = 4'd2;
            exp = (k < 4) ? 4'd12 : (k < 8) ? 4'd8 : (k < 12) ? 4'd4 : 4'd0;
            checks++;
            if (lvl0 !== exp) begin
                failures++;
                $display("FAIL fade_level k=%0d: got %0d expected %0d", k, lvl0, exp);
            end
        end
        checks++;
        if (on0 != 12 || on1 != 0) begin
            failures++;
            $display("FAIL fade_latched_duty: got ch0=%0d ch1=%0d expected ch0=12 ch1=0", on0, on1);
        end
        measure_period();
        checks++;
        if (hi[0] != 0 || hi[1] != 2) begin
            failures++;
            $display("FAIL fade_next_period: got ch0=%0d ch1=%0d expected ch0=0 ch1=2", hi[0], hi[1]);
        end
    endtask

    task automatic test_boundaries();
        logic [3:0] exp;
        // Zero brightness keeps every output dark.
        led_in = 4'b0100;
        bright_max = 4'd0;
        sync_wrap();
        measure_period();
        checks++;
        if (hi[0] + hi[1] + hi[2] + hi[3] != 0 || lvl2 !== 4'd0) begin
            failures++;
            $display("FAIL zero_bright: got %0d high cycles lvl2=%0d expected 0 and 0",
                     hi[0] + hi[1] + hi[2] + hi[3], lvl2);
        end
        // Saturation: 5 -> 1 -> 0, never wrapping.
        led_in = 4'b0001;
        bright_max = 4'd5;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) led_in = 4'b0000;
            exp = (k < 4) ? 4'd5 : (k < 8) ? 4'd1 : 4'd0;
            if (k == 3 || k == 4 || k == 8 || k == 12) begin
                checks++;
                if (lvl0 !== exp) begin
                    failures++;
                    $display("FAIL sat_level k=%0d: got %0d expected %0d", k, lvl0, exp);
                end
            end
        end
        // Load coincident with a fade tick wins.
        led_in = 4'b0001;
        bright_max = 4'd9;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 3) bright_max = 4'd7;
            if (k == 4) led_in = 4'b0000;
            exp = (k < 4) ? 4'd9 : (k < 8) ? 4'd7 : (k < 12) ? 4'd3 : 4'd0;
            if (k == 2 || k == 4 || k == 8 || k == 12) begin
                checks++;
                if (lvl0 !== exp) begin
                    failures++;
                    $display("FAIL load_vs_tick k=%0d: got %0d expected %0d", k, lvl0, exp);
                end
            end
        end
    endtask

    task automatic test_en();
        logic [3:0] exp;
        logic wrap_bad;
        led_in = 4'b0001;
        bright_max = 4'd15;
        en = 1'b1;
        sync_wrap();
        wrap_bad = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp = (k <= 15 && !(k >= 6 && k <= 10)) ? 4'b0001 : 4'b0000;
            checks++;
            if (led_out !== exp) begin
                failures++;
                $display("FAIL en_led_out k=%0d: got %b expected %b", k, led_out, exp);
            end
            if (pwm_wrap !== (k == 16)) wrap_bad = 1'b1;
            if (k == 5) en = 1'b0;
            if (k == 10) en = 1'b1;
        end
        checks++;
        if (wrap_bad) begin
            failures++;
            $display("FAIL en_wrap_cadence: got disturbed pwm_wrap expected single pulse at cycle 16");
        end
    endtask

    task automatic test_mid_reset();
        int first;
        int glow;
        led_in = 4'b0001;
        bright_max = 4'd12;
        sync_wrap();
        led_in = 4'b0000;
        repeat (4) step();
        checks++;
        if (lvl0 !== 4'd8) begin
            failures++;
            $display("FAIL mid_reset_pre_level: got %0d expected 8", lvl0);
        end
        reset = 1'b1;
        step();
        checks++;
        if (led_out !== 4'b0000 || pwm_wrap !== 1'b0 || {lvl0, lvl1, lvl2, lvl3} !== 16'h0000) begin
            failures++;
            $display("FAIL mid_reset_clear: got led_out=%b wrap=%b levels=%h expected 0 0 0000",
                     led_out, pwm_wrap, {lvl0, lvl1, lvl2, lvl3});
        end
        step();
        reset = 1'b0;
        first = 0;
        glow = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (pwm_wrap && first == 0) first = i;
            if (led_out != 4'b0000) glow++;
        end
        checks++;
        if (first != 16) begin
            failures++;
            $display("FAIL mid_reset_first_wrap: got %0d cycles expected 16", first);
        end
        checks++;
        if (glow != 0) begin
            failures++;
            $display("FAIL mid_reset_glow: got %0d lit cycles expected 0", glow);
        end
    endtask

    initial begin
        test_reset();
        test_full_on();
        test_back_to_back();
        test_fade();
        test_boundaries();
        test_en();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
